// File: rtl/serial_adder_sub.sv
// -----------------------------------------------------------------------------
// serial_adder_sub
//
// Bit-serial adder/subtractor. A single full-adder cell and a carry flop
// process a WIDTH-bit operand pair LSB-first, one bit per clock. Subtraction
// is done as a + ~b + 1. The result is published only once all bits are
// known, so sum/cout/ovf never show a partially computed value.
//
// Timing: start accepted at edge E0, bits processed on E1..E(WIDTH),
// done high in the cycle after E(WIDTH), back in IDLE after E(WIDTH+1).
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous, active-high reset
//   start  in   request an operation; accepted only while ready=1
//   sub    in   0: a+b+cin, 1: a-b (cin ignored); sampled with start
//   a      in   operand A, sampled on the accepting edge
//   b      in   operand B, sampled on the accepting edge
//   cin    in   carry-in for add mode; sampled with start
//   ready  out  idle and able to accept start
//   done   out  one-cycle pulse: sum/cout/ovf are final
//   sum    out  result, held until the next accepted start
//   cout   out  carry out of the MSB (sub mode: 1 = no borrow)
//   ovf    out  two's-complement signed overflow
// -----------------------------------------------------------------------------
module serial_adder_sub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             s;
   logic             c_next;
   logic             last_bit;
   logic [WIDTH-1:0] sum_sh_next;

   // Full-adder cell operating on the current LSBs.
   assign s        = a_sh[0] ^ b_sh[0] ^ carry;
   assign c_next   = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
   assign last_bit = (cnt == CW'(WIDTH - 1));

   // New bit enters at the MSB; after WIDTH shifts bit 0 of the result sits
   // at position 0.
   assign sum_sh_next = (sum_sh >> 1) | {s, {(WIDTH-1){1'b0}}};

   assign ready = (state_q == IDLE);
   assign done  = (state_q == DONE);

   // NOTE: always_ff holds only non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // NOTE: state_d gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_bit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the shift registers are reset as well as the visible result; they
   // are few flops and a defined value keeps post-reset behaviour repeatable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum    <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  // Subtract as a + ~b + 1: invert b and force the carry-in.
                  b_sh  <= sub ? ~b : b;
                  carry <= sub ? 1'b1 : cin;
                  cnt   <= '0;
               end
            end
            RUN: begin
               carry  <= c_next;
               sum_sh <= sum_sh_next;
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               if (last_bit) begin
                  sum  <= sum_sh_next;
                  cout <= c_next;
                  // carry still holds the carry into the MSB here.
                  ovf  <= carry ^ c_next;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_sub.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_sub
//
// Bench for serial_adder_sub. Two instances share the clock: an 8-bit one for
// directed, handshake, reset and random cases, and a 4-bit one for an
// exhaustive back-to-back sweep. Expected results come from a signed/unsigned
// integer reference model and are queued when an operation is issued; a
// monitor per instance pops and compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_serial_adder_sub;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // 8-bit instance
   logic       rst8, start8, sub8, cin8;
   logic [7:0] a8, b8;
   logic       ready8, done8, cout8, ovf8;
   logic [7:0] sum8;

   // 4-bit instance
   logic       rst4, start4, sub4, cin4;
   logic [3:0] a4, b4;
   logic       ready4, done4, cout4, ovf4;
   logic [3:0] sum4;

   serial_adder_sub #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst8), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
      .ready(ready8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
   );

   serial_adder_sub #(.WIDTH(4)) u4 (
      .clk(clk), .rst(rst4), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
      .ready(ready4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
   );

   int total = 0;
   int bad   = 0;
   int q8[$];
   int q4[$];
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: packs {ovf, cout, sum} for a w-bit operation using plain
   // integer arithmetic on the unsigned and signed readings of the operands.
   function automatic int model(input int w, input int a, input int b, input int s, input int c);
      int m, full, sa, sb, sr, res, co, ov;
      m  = 1 << w;
      sa = (a >= m / 2) ? a - m : a;
      sb = (b >= m / 2) ? b - m : b;
      if (s == 0) begin
         full = a + b + c;
         sr   = sa + sb + c;
         co   = (full >= m) ? 1 : 0;
      end else begin
         full = a - b;
         sr   = sa - sb;
         co   = (a >= b) ? 1 : 0;
      end
      res = ((full % m) + m) % m;
      ov  = (sr > m / 2 - 1 || sr < -(m / 2)) ? 1 : 0;
      return (ov << (w + 1)) | (co << w) | res;
   endfunction

   // Monitors
   logic prev8 = 1'b0;
   logic prev4 = 1'b0;

   always @(negedge clk) begin
      if (done8) begin
         check("done8_width", 32'(prev8), 32'd0);
         check("sb8_nonempty", 32'(q8.size() > 0), 32'd1);
         if (q8.size() > 0) check("result8", 32'({ovf8, cout8, sum8}), q8.pop_front());
      end
      prev8 <= done8;
   end

   always @(negedge clk) begin
      if (done4) begin
         check("done4_width", 32'(prev4), 32'd0);
         check("sb4_nonempty", 32'(q4.size() > 0), 32'd1);
         if (q4.size() > 0) check("result4", 32'({ovf4, cout4, sum4}), q4.pop_front());
      end
      prev4 <= done4;
   end

   // One 8-bit operation with latency, ready and hold checks. With noise set,
   // start is pulsed and the operand inputs scrambled on every busy cycle.
   task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                       input logic tc, input bit noise);
      int n;
      int lat;
      int e;
      n = 0;
      @(negedge clk);
      while (!ready8 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("ready8_wait", 32'(ready8), 32'd1);
      a8 = ta; b8 = tb_v; sub8 = ts; cin8 = tc; start8 = 1'b1;
      e = model(8, int'(ta), int'(tb_v), int'(ts), int'(tc));
      q8.push_back(e);
      @(posedge clk);   // accepting edge E0
      lat = -1;
      for (int k = 1; k <= 10; k++) begin
         #1;
         if (noise && k <= 9) begin
            start8 = 1'b1;
            a8     = 8'($urandom);
            b8     = 8'($urandom);
            sub8   = 1'($urandom);
            cin8   = 1'($urandom);
         end else begin
            start8 = 1'b0;
         end
         @(negedge clk);   // observes state after edge E(k-1)
         if (lat < 0 && done8) lat = k - 1;
         if (k <= 9) check("ready8_busy", 32'(ready8), 32'd0);
         else        check("ready8_back", 32'(ready8), 32'd1);
         @(posedge clk);
      end
      check("latency8", 32'(lat), 32'd8);
      #1;
      check("sum8_held", 32'({ovf8, cout8, sum8}), 32'(e));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int last_acc;
      bit have_prev;

      rst8 = 1'b1; start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
      rst4 = 1'b1; start4 = 1'b0; sub4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
      repeat (2) @(negedge clk);

      check("rst8_ready", 32'(ready8), 32'd1);
      check("rst8_done",  32'(done8),  32'd0);
      check("rst8_res",   32'({ovf8, cout8, sum8}), 32'd0);
      check("rst4_ready", 32'(ready4), 32'd1);
      check("rst4_res",   32'({ovf4, cout4, sum4}), 32'd0);
      rst8 = 1'b0;
      rst4 = 1'b0;

      // Directed cases
      run8(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);
      run8(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0);
      run8(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
      run8(8'h05, 8'h07, 1'b1, 1'b0, 1'b0);
      run8(8'h80, 8'h01, 1'b1, 1'b0, 1'b0);
      // Ignored start and input changes while busy
      run8(8'h3C, 8'hA5, 1'b0, 1'b1, 1'b1);
      run8(8'h10, 8'h20, 1'b1, 1'b1, 1'b1);

      // Reset on the 4th RUN edge: aborted op, no expectation queued.
      @(negedge clk);
      a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b0; cin8 = 1'b1; start8 = 1'b1;
      @(posedge clk);          // E0
      #1 start8 = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst8 = 1'b1;
      #1;
      check("abort_ready", 32'(ready8), 32'd1);
      check("abort_done",  32'(done8),  32'd0);
      check("abort_res",   32'({ovf8, cout8, sum8}), 32'd0);
      repeat (2) @(negedge clk);
      rst8 = 1'b0;
      repeat (10) begin
         @(negedge clk);
         check("abort_no_done", 32'(done8), 32'd0);
      end
      run8(8'h12, 8'h34, 1'b0, 1'b0, 1'b0);

      // Random operations, half with busy-time noise
      for (int i = 0; i < 40; i++)
         run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

      // WIDTH=4 exhaustive sweep, start held high: accept at every ready edge.
      have_prev = 1'b0;
      last_acc  = 0;
      for (int va = 0; va < 16; va++)
         for (int vb = 0; vb < 16; vb++)
            for (int vs = 0; vs < 2; vs++)
               for (int vc = 0; vc < 2; vc++) begin
                  n = 0;
                  @(negedge clk);
                  while (!ready4 && n < 20) begin
                     @(negedge clk);
                     n++;
                  end
                  check("ready4_wait", 32'(ready4), 32'd1);
                  a4 = 4'(va); b4 = 4'(vb); sub4 = 1'(vs); cin4 = 1'(vc);
                  start4 = 1'b1;
                  q4.push_back(model(4, va, vb, vs, vc));
                  if (have_prev) check("thru4", 32'(cyc - last_acc), 32'd6);
                  last_acc  = cyc;
                  have_prev = 1'b1;
                  @(posedge clk);
               end
      #1 start4 = 1'b0;

      repeat (12) @(negedge clk);
      check("sb8_drained", 32'(q8.size()), 32'd0);
      check("sb4_drained", 32'(q4.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
